// File: rtl/elevator_door_fsm.sv
// Door cycle controller for an N-floor car: open, dwell, close, obstruction reversal.
// Motor commands and status flags are all registered; motion is permitted only while closed.
module elevator_door_fsm #(
    parameter int NUM_FLOORS    = 6,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DWELL_CYCLES  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] currentFloor,
    input  logic                  car_stopped,
    input  logic                  open_req,
    input  logic                  close_req,
    input  logic                  obstruct,
    output logic [NUM_FLOORS-1:0] openDoor,
    output logic [NUM_FLOORS-1:0] closeDoor,
    output logic                  door_closed,
    output logic                  closed_pulse,
    output logic                  door_fault
);

    localparam int MAXC = (TRAVEL_CYCLES > DWELL_CYCLES) ?
                          TRAVEL_CYCLES : DWELL_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] T_ZERO      = '0;
    localparam logic [TW-1:0] T_ONE       = TW'(1);

    localparam logic [NUM_FLOORS-1:0] F_ZERO = '0;
    localparam logic [NUM_FLOORS-1:0] F_ONE  = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_CLOSED,
        S_OPENING,
        S_OPEN,
        S_CLOSING
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [NUM_FLOORS-1:0]   floor_q, floor_d;
    logic [NUM_FLOORS-1:0]   open_q, open_d;
    logic [NUM_FLOORS-1:0]   close_q, close_d;
    logic                    closed_q, closed_d;
    logic                    pulse_q, pulse_d;
    logic                    fault_q, fault_d;
    logic [NUM_FLOORS-1:0]   lowest_floor;

    // Isolate the lowest set bit so a multi-hot floor bus picks the lowest floor.
    assign lowest_floor = currentFloor & (~currentFloor + F_ONE);

    // Next-state, timer, floor latch and registered-output next values.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        floor_d  = floor_q;
        pulse_d  = 1'b0;
        fault_d  = fault_q;
        open_d   = F_ZERO;
        close_d  = F_ZERO;
        closed_d = 1'b0;

        if (state_q != S_CLOSED && !car_stopped) begin
            fault_d = 1'b1;
        end

        unique case (state_q)
            S_CLOSED: begin
                if (open_req && car_stopped && currentFloor != F_ZERO) begin
                    floor_d = lowest_floor;
                    timer_d = TRAVEL_LAST;
                    state_d = S_OPENING;
                end
            end
            S_OPENING: begin
                if (timer_q == T_ZERO) begin
                    timer_d = DWELL_LAST;
                    state_d = S_OPEN;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_OPEN: begin
                if (obstruct || open_req) begin
                    timer_d = DWELL_LAST;
                end else if (close_req) begin
                    timer_d = TRAVEL_LAST;
                    state_d = S_CLOSING;
                end else if (timer_q == T_ZERO) begin
                    timer_d = TRAVEL_LAST;
                    state_d = S_CLOSING;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_CLOSING: begin
                if (obstruct || open_req) begin
                    // Reopen for as long as the door has been closing so far.
                    timer_d = TRAVEL_LAST - timer_q;
                    state_d = S_OPENING;
                end else if (timer_q == T_ZERO) begin
                    timer_d = T_ZERO;
                    floor_d = F_ZERO;
                    pulse_d = 1'b1;
                    state_d = S_CLOSED;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            default: begin
                state_d = S_CLOSED;
                timer_d = T_ZERO;
                floor_d = F_ZERO;
            end
        endcase

        // Outputs follow the state being entered so they are registered with it.
        unique case (state_d)
            S_OPENING: open_d   = floor_d;
            S_CLOSING: close_d  = floor_d;
            S_CLOSED:  closed_d = 1'b1;
            default:   closed_d = 1'b0;
        endcase
    end

    // State, timer, latched floor and output registers with async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_CLOSED;
            timer_q  <= T_ZERO;
            floor_q  <= F_ZERO;
            open_q   <= F_ZERO;
            close_q  <= F_ZERO;
            closed_q <= 1'b1;
            pulse_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            floor_q  <= floor_d;
            open_q   <= open_d;
            close_q  <= close_d;
            closed_q <= closed_d;
            pulse_q  <= pulse_d;
            fault_q  <= fault_d;
        end
    end

    assign openDoor     = open_q;
    assign closeDoor    = close_q;
    assign door_closed  = closed_q;
    assign closed_pulse = pulse_q;
    assign door_fault   = fault_q;

endmodule

// File: tb/tb_elevator_door_fsm.sv
// Directed bench for elevator_door_fsm with default parameters.
// Expected values are hand-derived from the door-cycle timing.
module tb_elevator_door_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] currentFloor;
    logic       car_stopped;
    logic       open_req;
    logic       close_req;
    logic       obstruct;
    logic [5:0] openDoor;
    logic [5:0] closeDoor;
    logic       door_closed;
    logic       closed_pulse;
    logic       door_fault;

    int n_chk  = 0;
    int n_fail = 0;

    elevator_door_fsm #(
        .NUM_FLOORS    (6),
        .TRAVEL_CYCLES (4),
        .DWELL_CYCLES  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .currentFloor (currentFloor),
        .car_stopped  (car_stopped),
        .open_req     (open_req),
        .close_req    (close_req),
        .obstruct     (obstruct),
        .openDoor     (openDoor),
        .closeDoor    (closeDoor),
        .door_closed  (door_closed),
        .closed_pulse (closed_pulse),
        .door_fault   (door_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string tag, input logic [5:0] obs,
                         input logic [5:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk_v({tag, "_open"}, openDoor, 6'b0);
        chk_v({tag, "_close"}, closeDoor, 6'b0);
        chk_b({tag, "_closed"}, door_closed, 1'b1);
    endtask

    task automatic chk_dwell(input string tag);
        chk_v({tag, "_open"}, openDoor, 6'b0);
        chk_v({tag, "_close"}, closeDoor, 6'b0);
        chk_b({tag, "_closed"}, door_closed, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        currentFloor = 6'b0;
        car_stopped  = 1'b0;
        open_req     = 1'b0;
        close_req    = 1'b0;
        obstruct     = 1'b0;

        // Reset state, during and after reset
        step();
        chk_idle("rst_in");
        chk_b("rst_in_pulse", closed_pulse, 1'b0);
        chk_b("rst_in_fault", door_fault, 1'b0);
        reset = 1'b0;
        step();
        chk_idle("rst_out");
        chk_b("rst_out_pulse", closed_pulse, 1'b0);
        chk_b("rst_out_fault", door_fault, 1'b0);

        // Full automatic cycle at floor 3
        currentFloor = 6'b001000;
        car_stopped  = 1'b1;
        open_req     = 1'b1;
        step();
        open_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk_v("t2_opening", openDoor, 6'b001000);
            chk_v("t2_opening_cl", closeDoor, 6'b0);
            chk_b("t2_opening_dc", door_closed, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk_dwell("t2_dwell");
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk_v("t2_closing", closeDoor, 6'b001000);
            chk_v("t2_closing_op", openDoor, 6'b0);
            chk_b("t2_closing_dc", door_closed, 1'b0);
        end
        step();
        chk_idle("t2_done");
        chk_b("t2_pulse", closed_pulse, 1'b1);
        step();
        chk_b("t2_pulse_end", closed_pulse, 1'b0);
        chk_b("t2_closed", door_closed, 1'b1);

        // Obstruction after one closing cycle reverses for one cycle
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        repeat (3) step();
        chk_v("t3_open_last", openDoor, 6'b001000);
        repeat (8) step();
        chk_dwell("t3_dwell_last");
        step();
        chk_v("t3_close1", closeDoor, 6'b001000);
        obstruct = 1'b1;
        step();
        obstruct = 1'b0;
        chk_v("t3_reopen", openDoor, 6'b001000);
        chk_v("t3_reopen_cl", closeDoor, 6'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk_dwell("t3_redwell");
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk_v("t3_reclose", closeDoor, 6'b001000);
        end
        step();
        chk_b("t3_pulse", closed_pulse, 1'b1);
        chk_b("t3_closed", door_closed, 1'b1);

        // Held obstruction keeps the door open
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        repeat (4) step();
        obstruct = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk_dwell("t3_hold");
        end
        obstruct  = 1'b0;
        close_req = 1'b1;
        step();
        close_req = 1'b0;
        chk_v("t3_hold_close", closeDoor, 6'b001000);
        repeat (3) step();
        step();
        chk_b("t3_hold_pulse", closed_pulse, 1'b1);

        // close_req on the third OPEN cycle
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk_dwell("t4_open");
        end
        close_req = 1'b1;
        step();
        close_req = 1'b0;
        chk_v("t4_close", closeDoor, 6'b001000);
        chk_b("t4_close_dc", door_closed, 1'b0);
        repeat (3) step();
        chk_v("t4_close_last", closeDoor, 6'b001000);
        step();
        chk_b("t4_pulse", closed_pulse, 1'b1);

        // Multi-hot floor resolves low; floor changes ignored once latched
        currentFloor = 6'b010100;
        open_req     = 1'b1;
        step();
        open_req = 1'b0;
        chk_v("t5_lowbit", openDoor, 6'b000100);
        currentFloor = 6'b000001;
        step();
        chk_v("t5_latched", openDoor, 6'b000100);
        repeat (3) step();
        close_req = 1'b1;
        step();
        close_req = 1'b0;
        chk_v("t5_close", closeDoor, 6'b000100);
        repeat (4) step();
        chk_b("t5_pulse", closed_pulse, 1'b1);

        // No opening between floors or while moving
        currentFloor = 6'b0;
        open_req     = 1'b1;
        step();
        chk_idle("t5_nofloor");
        step();
        chk_idle("t5_nofloor2");
        currentFloor = 6'b001000;
        car_stopped  = 1'b0;
        step();
        chk_idle("t5_moving");
        chk_b("t5_moving_fault", door_fault, 1'b0);
        open_req    = 1'b0;
        car_stopped = 1'b1;

        // Fault on car_stopped drop while open, then async reset mid-opening
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        repeat (4) step();
        chk_dwell("t6_open");
        chk_b("t6_nofault", door_fault, 1'b0);
        car_stopped = 1'b0;
        step();
        car_stopped = 1'b1;
        chk_b("t6_fault", door_fault, 1'b1);
        close_req = 1'b1;
        step();
        close_req = 1'b0;
        chk_v("t6_closing", closeDoor, 6'b001000);
        open_req = 1'b1;
        step();
        open_req = 1'b0;
        chk_v("t6_reopen", openDoor, 6'b001000);
        chk_b("t6_fault_sticky", door_fault, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("t6_async");
        chk_b("t6_async_pulse", closed_pulse, 1'b0);
        chk_b("t6_async_fault", door_fault, 1'b0);
        step();
        reset = 1'b0;
        step();
        chk_idle("t6_after");
        chk_b("t6_after_fault", door_fault, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
